// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring integer divider. It produces one quotient bit per
//   clock and handles signed and unsigned operands. It sits beside the ALU in
//   the execute stage. Valid/ready handshakes on both sides let the pipeline
//   stall while a divide is in flight.
//
//   Optional feature macro: SEQ_DIVIDER_EARLY_OUT_EN
//     When defined, operands with b != 0 and |a| < |b| finish one edge after
//     acceptance with quot = 0 and rem = a. When undefined, such operands take
//     the full latency and give identical results.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     operands present
//   in_ready     divider idle and able to accept
//   in_signed    1 = two's-complement divide, 0 = unsigned
//   in_a         dividend (WORD_WIDTH)
//   in_b         divisor  (WORD_WIDTH)
//   out_valid    result present, held until consumed
//   out_ready    consumer accepts result
//   out_quot     quotient  (WORD_WIDTH)
//   out_rem      remainder (WORD_WIDTH)
//   out_div_zero divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_signed,
    input  logic [WORD_WIDTH-1:0] in_a,
    input  logic [WORD_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_quot,
    output logic [WORD_WIDTH-1:0] out_rem,
    output logic                  out_div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  sign_a;
    logic                  sign_b;
    logic [WORD_WIDTH-1:0] b_mag;
    logic [WORD_WIDTH-1:0] rem;
    logic [WORD_WIDTH-1:0] quot;

    // Operand magnitudes at the accept cycle. The most-negative value maps to
    // 2^(W-1), which still fits unsigned in W bits.
    logic                  in_sign_a;
    logic                  in_sign_b;
    logic [WORD_WIDTH-1:0] in_a_mag;
    logic [WORD_WIDTH-1:0] in_b_mag;

    // One restoring step. The shifted remainder needs W+1 bits because it can
    // reach 2*|b|-1. The trial difference's top bit is its sign.
    logic [WORD_WIDTH:0]   rem_shift;
    logic [WORD_WIDTH:0]   trial;
    logic                  trial_ok;

    // NOTE: every signal driven here gets a value first, so no path leaves it
    // unassigned and no latch can be inferred.
    always_comb begin
        in_sign_a = in_signed & in_a[WORD_WIDTH-1];
        in_sign_b = in_signed & in_b[WORD_WIDTH-1];
        in_a_mag  = in_sign_a ? (~in_a + 1'b1) : in_a;
        in_b_mag  = in_sign_b ? (~in_b + 1'b1) : in_b;
        rem_shift = {rem, quot[WORD_WIDTH-1]};
        trial     = rem_shift - {1'b0, b_mag};
        trial_ok  = ~trial[WORD_WIDTH];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            b_mag        <= '0;
            rem          <= '0;
            quot         <= '0;
            out_quot     <= '0;
            out_rem      <= '0;
            out_div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        b_mag  <= in_b_mag;
                        if (in_b == '0) begin
                            out_quot     <= '1;
                            out_rem      <= in_a;
                            out_div_zero <= 1'b1;
                            state        <= DONE;
                        end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                        else if (in_a_mag < in_b_mag) begin
                            // The quotient is zero, and the dividend is already
                            // the remainder with the correct sign.
                            out_quot     <= '0;
                            out_rem      <= in_a;
                            out_div_zero <= 1'b0;
                            state        <= DONE;
                        end
`endif
                        else begin
                            rem   <= '0;
                            quot  <= in_a_mag;
                            cnt   <= CNT_WIDTH'(WORD_WIDTH);
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    // rem < |b| holds on entry, so a kept trial fits in W bits.
                    rem  <= trial_ok ? trial[WORD_WIDTH-1:0]
                                     : rem_shift[WORD_WIDTH-1:0];
                    quot <= {quot[WORD_WIDTH-2:0], trial_ok};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    // Most-negative / -1 wraps naturally to most-negative.
                    out_quot     <= (sign_a ^ sign_b) ? (~quot + 1'b1) : quot;
                    out_rem      <= sign_a ? (~rem + 1'b1) : rem;
                    out_div_zero <= 1'b0;
                    state        <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed testbench for seq_divider (WORD_WIDTH = 32). Each scenario task
//   drives its stimulus and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 32;
    localparam int FULL_LAT = W + 2;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = FULL_LAT;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;
    logic         out_div_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WORD_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quot     (out_quot),
        .out_rem      (out_rem),
        .out_div_zero (out_div_zero)
    );

    always #5 clk = ~clk;

    // Issues one operation and waits for out_valid. It does no checking.
    // lat counts edges from the accepting edge to the edge that raised
    // out_valid. lat = -1 means a bound expired.
    task automatic issue(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat);
        int guard;
        lat   = -1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) return;
        in_signed = s; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_signed = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quot !== '0 ||
            out_rem !== '0 || out_div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b q=%h r=%h dz=%b, need rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, out_quot, out_rem, out_div_zero);
        end
    endtask

    // Directed vectors: signedness, a, b, quot, rem, div_zero, latency.
    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        string        name;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.s, v.a, v.b, lat);
        checks++;
        if (lat !== v.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, need %0d", v.name, lat, v.lat);
        end
        checks++;
        if (out_quot !== v.q || out_rem !== v.r || out_div_zero !== v.dz) begin
            errors++;
            $display("FAIL %s_result: got q=%h r=%h dz=%b, need q=%h r=%h dz=%b",
                     v.name, out_quot, out_rem, out_div_zero, v.q, v.r, v.dz);
        end
        consume();
    endtask

    task automatic test_divide();
        vec_t vecs[8];
        vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, FULL_LAT, "udiv_100_7"};
        vecs[1] = '{1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, FULL_LAT, "sdiv_m100_7"};
        vecs[2] = '{1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, FULL_LAT, "sdiv_100_m7"};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, FULL_LAT, "sdiv_overflow"};
        vecs[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, SMALL_LAT, "udiv_big"};
        vecs[5] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, FULL_LAT, "sdiv_m100_m7"};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, FULL_LAT, "udiv_max_1"};
        vecs[7] = '{1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, SMALL_LAT, "udiv_5_9"};
        foreach (vecs[i]) run_vec(vecs[i]);
    endtask

    task automatic test_div_zero();
        vec_t vu;
        vec_t vs;
        vu = '{1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, "udiv_zero"};
        vs = '{1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, "sdiv_zero"};
        run_vec(vu);
        run_vec(vs);
    endtask

    task automatic test_backpressure();
        int lat;
        issue(1'b0, 32'd1000, 32'd3, lat);
        checks++;
        if (lat !== FULL_LAT || out_quot !== 32'd333 || out_rem !== 32'd1) begin
            errors++;
            $display("FAIL bp_result: got lat=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                     lat, out_quot, out_rem, FULL_LAT, 32'd333, 32'd1);
        end
        // Offer a competing operation that must be ignored while blocked.
        in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd77; in_b = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quot !== 32'd333 ||
                out_rem !== 32'd1 || out_div_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b q=%h r=%h dz=%b, need vld=1 rdy=0 q=%h r=%h dz=0",
                         i, out_valid, in_ready, out_quot, out_rem, out_div_zero, 32'd333, 32'd1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
        end
        // One more idle edge: the blocked request must not have been taken.
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_accept: got rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        vec_t v;
        @(posedge clk); #1;
        in_signed = 1'b0; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quot !== '0 ||
            out_rem !== '0 || out_div_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_values: got rdy=%b vld=%b q=%h r=%h dz=%b, need rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, out_quot, out_rem, out_div_zero);
        end
        // The aborted result must never appear.
        repeat (FULL_LAT) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_discard: got vld=%b, need vld=0", out_valid);
        end
        v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, FULL_LAT, "after_abort_9_3"};
        run_vec(v);
    endtask

    task automatic test_back_to_back();
        vec_t v1;
        vec_t v2;
        v1 = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, FULL_LAT, "b2b_m7_2"};
        v2 = '{1'b0, 32'd65536, 32'd256, 32'd256, 32'd0, 1'b0, FULL_LAT, "b2b_64k_256"};
        run_vec(v1);
        run_vec(v2);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        test_reset();
        test_divide();
        test_div_zero();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle integer divider. It is the inverse counterpart of the ALU multiply paths (Alu_Mul, LongUMul, LongSMul).
- Computes quotient and remainder of a CPU word dividend by a CPU word divisor, signed or unsigned.
- Uses restoring division, one quotient bit per clock.
- Sits beside the ALU in the execute stage. Valid/ready handshake on input and output, so the pipeline stalls while it is busy.

Parameters:
- WORD_WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > WORD_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands present
- in_ready  output  1  divider idle and able to accept
- in_signed  input  1  1 = two's-complement divide, 0 = unsigned
- in_a  input  WORD_WIDTH  dividend
- in_b  input  WORD_WIDTH  divisor
- out_valid  output  1  result present; held until consumed
- out_ready  input  1  consumer accepts result
- out_quot  output  WORD_WIDTH  quotient
- out_rem  output  WORD_WIDTH  remainder
- out_div_zero  output  1  divisor was zero

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_quot=0, out_rem=0, out_div_zero=0, counter=0.
- rst asserted mid-operation aborts the divide. The next cycle reads as reset values and the result is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - in_ready=1. Accept on in_valid && in_ready.
  - On accept, latch signedness, sign_a=in_signed&in_a[MSB], sign_b=in_signed&in_b[MSB].
  - Latch magnitudes |a| and |b| (two's-complement negate when the sign bit is set). Latch the original in_a.
  - in_b==0: go to DONE next edge with out_quot=all ones, out_rem=in_a (original), out_div_zero=1.
  - Otherwise: clear the partial remainder (WORD_WIDTH+1 bits), load the quotient shift register with |a|, counter=WORD_WIDTH, go to RUN.
- RUN (one iteration per cycle):
  - Shift {rem,quot} left 1.
  - trial = rem_shifted - {0,|b|}. If trial is non-negative, rem=trial and quot LSB=1; else quot LSB=0.
  - Decrement counter. When the counter reaches 0 after the update, go to FIX.
- FIX (one cycle):
  - out_quot = (sign_a^sign_b) ? -quot : quot.
  - out_rem = sign_a ? -rem : rem.
  - out_div_zero=0. Go to DONE.
- DONE: out_valid=1, in_ready=0. Outputs held stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE; out_valid drops next edge.
- Latency:
  - Normal divide: out_valid high WORD_WIDTH+2 edges after the accepting edge (34 for WORD_WIDTH=32).
  - Divide by zero: out_valid high 1 edge after acceptance.
- Back-to-back: a new operation is accepted only in IDLE. No new operation is accepted in the same cycle a result is consumed. Throughput is one divide per WORD_WIDTH+3 cycles at best.
- Signed overflow: most-negative / -1 gives quot=most-negative (wraps), rem=0, out_div_zero=0. The natural result of the magnitude path matches this; no special case is needed.
- Arithmetic rules:
  - Quotient truncates toward zero. Remainder takes the sign of the dividend. a == quot*b + rem always holds for b!=0.
  - Magnitude of the most-negative value is 2^(W-1), representable unsigned in W bits.
- Input changes: in_a, in_b and in_signed are ignored outside the accepting cycle.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined:
  - In IDLE on accept, if b!=0 and |a| < |b| (unsigned magnitude compare), skip RUN/FIX.
  - Go directly to DONE next edge with out_quot=0, out_rem=in_a (original), out_div_zero=0. Latency is 1 edge.
- Undefined: such operands take the full WORD_WIDTH+2 latency and give identical result values.

Test Plan:
- Unsigned 100/7 -> quot=14, rem=2, div_zero=0, out_valid exactly 34 edges after accept (W=32).
- Signed -100/7 (0xFFFFFF9C, 7) -> quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2). Signed 100/-7 -> quot=-14, rem=2.
- Divide by zero: a=0x12345678, b=0, signed and unsigned -> quot=0xFFFFFFFF, rem=0x12345678, div_zero=1, 1-edge latency.
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0. Unsigned same operands -> quot=0, rem=0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0, in_valid ignored. Then out_ready=1 for 1 cycle -> next cycle in_ready=1, out_valid=0.
- Assert rst at RUN iteration 10 -> next cycle all reset values. A following 9/3 -> quot=3, rem=0. With SEQ_DIVIDER_EARLY_OUT_EN, 5/9 -> quot=0, rem=5 after 1 edge.
